clk_sched: RTL and testbench

- Run/stop/step/halt scheduler for the divided-clock resource.
- Sits between the clocken divider (clken, clken2 ticks) and the SAP-2 CPU.
- Gates the ticks into CPU enables (cpu_en, cpu_en2) according to the front-panel run/step controls and the HLT control signal.
- Owns the one-hot T-state ring counter that sequences the control unit.

---
 rtl/clk_sched.sv | 148 ++++++++++++++
 tb/tb_clk_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sched.sv
// Run/stop/step/halt scheduler: gates divider ticks into CPU enables and owns the T-state ring.
// Optional CLK_SCHED_ISTEP_EN adds an istep input that makes a step run a whole instruction.
module clk_sched #(
   parameter int unsigned NSTATES = 6
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic               clken,
   input  logic               clken2,
   input  logic               run,
   input  logic               step,
   input  logic               resume,
   input  logic               halt,
   input  logic               tclr,
`ifdef CLK_SCHED_ISTEP_EN
   input  logic               istep,
`endif
   output logic               cpu_en,
   output logic               cpu_en2,
   output logic [NSTATES-1:0] tstate,
   output logic               halted,
   output logic [1:0]         sched_st
);

   localparam logic [1:0] StStop   = 2'd0;
   localparam logic [1:0] StRun    = 2'd1;
   localparam logic [1:0] StArmed  = 2'd2;
   localparam logic [1:0] StHalted = 2'd3;

   localparam logic [NSTATES-1:0] TFirst = NSTATES'(1);

   logic [1:0]         state_q, state_d;
   logic               pend2_q, pend2_d;
   logic               cpu_en_q, cpu_en_d;
   logic               cpu_en2_q, cpu_en2_d;
   logic [NSTATES-1:0] tstate_q, tstate_d;
   logic               halted_q, halted_d;
   logic               gate_open;
`ifdef CLK_SCHED_ISTEP_EN
   logic               armi_q, armi_d;
`endif

   assign gate_open = (state_q == StRun) || (state_q == StArmed);

   always_comb begin
      cpu_en_d  = clken & gate_open;
      cpu_en2_d = clken2 & pend2_q;
      // A passed phase-A tick always owes exactly one phase-B tick.
      pend2_d   = pend2_q;
      if (cpu_en_d) begin
         pend2_d = 1'b1;
      end else if (cpu_en2_d) begin
         pend2_d = 1'b0;
      end

      tstate_d = tstate_q;
      if (cpu_en_q) begin
         tstate_d = tclr ? TFirst : {tstate_q[NSTATES-2:0], tstate_q[NSTATES-1]};
      end

      state_d = state_q;
`ifdef CLK_SCHED_ISTEP_EN
      armi_d  = armi_q;
`endif
      if (cpu_en_q && halt) begin
         state_d = StHalted;
      end else begin
         unique case (state_q)
            StStop: begin
               if (run) begin
                  state_d = StRun;
               end else if (step) begin
                  state_d = StArmed;
`ifdef CLK_SCHED_ISTEP_EN
                  armi_d  = istep;
`endif
               end
            end
            StRun: begin
               if (!run) state_d = StStop;
            end
            StArmed: begin
`ifdef CLK_SCHED_ISTEP_EN
               if (armi_q) begin
                  // Instruction step ends on the last T-state or a short-cycle clear.
                  if (cpu_en_q && (tclr || tstate_q[NSTATES-1])) begin
                     state_d = StStop;
                  end else if (run) begin
                     state_d = StRun;
                  end
               end else if (clken) begin
                  state_d = StStop;
               end else if (run) begin
                  state_d = StRun;
               end
`else
               if (clken) begin
                  state_d = StStop;
               end else if (run) begin
                  state_d = StRun;
               end
`endif
            end
            StHalted: begin
               if (resume) state_d = run ? StRun : StStop;
            end
            default: state_d = StStop;
         endcase
      end

      halted_d = (state_d == StHalted);
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q   <= StStop;
         pend2_q   <= 1'b0;
         cpu_en_q  <= 1'b0;
         cpu_en2_q <= 1'b0;
         tstate_q  <= TFirst;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend2_q   <= pend2_d;
         cpu_en_q  <= cpu_en_d;
         cpu_en2_q <= cpu_en2_d;
         tstate_q  <= tstate_d;
         halted_q  <= halted_d;
      end
   end

`ifdef CLK_SCHED_ISTEP_EN
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         armi_q <= 1'b0;
      end else begin
         armi_q <= armi_d;
      end
   end
`endif

   assign cpu_en   = cpu_en_q;
   assign cpu_en2  = cpu_en2_q;
   assign tstate   = tstate_q;
   assign halted   = halted_q;
   assign sched_st = state_q;

endmodule

// File: tb/tb_clk_sched.sv
// Randomised and directed bench for clk_sched against an index-based behavioural model.
module tb_clk_sched;

   localparam int N = 6;

   logic         sysclk = 1'b0;
   logic         reset  = 1'b0;
   logic         clken  = 1'b0;
   logic         clken2 = 1'b0;
   logic         run    = 1'b0;
   logic         step   = 1'b0;
   logic         resume = 1'b0;
   logic         halt   = 1'b0;
   logic         tclr   = 1'b0;
`ifdef CLK_SCHED_ISTEP_EN
   logic         istep  = 1'b0;
`endif
   logic         cpu_en;
   logic         cpu_en2;
   logic [N-1:0] tstate;
   logic         halted;
   logic [1:0]   sched_st;

   clk_sched #(.NSTATES(N)) dut (
      .sysclk  (sysclk),
      .reset   (reset),
      .clken   (clken),
      .clken2  (clken2),
      .run     (run),
      .step    (step),
      .resume  (resume),
      .halt    (halt),
      .tclr    (tclr),
`ifdef CLK_SCHED_ISTEP_EN
      .istep   (istep),
`endif
      .cpu_en  (cpu_en),
      .cpu_en2 (cpu_en2),
      .tstate  (tstate),
      .halted  (halted),
      .sched_st(sched_st)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: mode 0 stop, 1 run, 2 armed, 3 halted; T-state kept as an integer index.
   int m_mode, m_t;
   bit m_en, m_en2, m_pend, m_armi;
   int div_cnt = 0;
   int n_en, n_en2;

   task automatic model_reset();
      m_mode = 0; m_t = 0; m_en = 0; m_en2 = 0; m_pend = 0; m_armi = 0;
   endtask

   task automatic model_step();
      bit en_n, en2_n, pend_n, armi_n, is_i;
      int t_n, mode_n;
      is_i = 1'b0;
`ifdef CLK_SCHED_ISTEP_EN
      is_i = istep;
`endif
      en_n   = clken && (m_mode == 1 || m_mode == 2);
      en2_n  = clken2 && m_pend;
      pend_n = en_n ? 1'b1 : (en2_n ? 1'b0 : m_pend);
      t_n    = m_t;
      if (m_en) t_n = tclr ? 0 : (m_t + 1) % N;
      mode_n = m_mode;
      armi_n = m_armi;
      if (m_en && halt) mode_n = 3;
      else begin
         case (m_mode)
            0: if (run) mode_n = 1; else if (step) begin mode_n = 2; armi_n = is_i; end
            1: if (!run) mode_n = 0;
            2: begin
               if (m_armi) begin
                  if (m_en && (tclr || m_t == N - 1)) mode_n = 0;
                  else if (run) mode_n = 1;
               end else if (clken) mode_n = 0;
               else if (run) mode_n = 1;
            end
            default: if (resume) mode_n = run ? 1 : 0;
         endcase
      end
      m_en = en_n; m_en2 = en2_n; m_pend = pend_n; m_t = t_n; m_mode = mode_n; m_armi = armi_n;
   endtask

   // One sysclk: model updates at the edge, DUT compared on the falling edge.
   task automatic tick();
      @(posedge sysclk);
      if (reset) model_step();
      else model_reset();
      @(negedge sysclk);
      check("cpu_en", 32'(cpu_en), 32'(m_en));
      check("cpu_en2", 32'(cpu_en2), 32'(m_en2));
      check("tstate", 32'(tstate), 32'(1) << m_t);
      check("halted", 32'(halted), 32'(m_mode == 3));
      check("sched_st", 32'(sched_st), 32'(m_mode));
      n_en  += int'(cpu_en);
      n_en2 += int'(cpu_en2);
      div_cnt = (div_cnt + 1) % 8;
      clken   = (div_cnt == 0);
      clken2  = (div_cnt == 4);
   endtask

   task automatic align();
      for (int i = 0; i < 8 && div_cnt != 1; i++) tick();
   endtask

   initial begin
      int t_before;
      model_reset();
      clken = 1'b1;
      repeat (3) tick();
      reset = 1'b1;

      // Stopped: no enables at all.
      n_en = 0; n_en2 = 0;
      repeat (100) tick();
      check("stop_no_pulses", 32'(n_en + n_en2), 32'd0);
      check("stop_tstate", 32'(tstate), 32'h01);

      // Free run: six enables wrap the ring to T1.
      run = 1'b1; n_en = 0;
      for (int i = 0; i < 100 && n_en < 6; i++) tick();
      check("run_six_pulses", 32'(n_en), 32'd6);
      tick();
      check("run_wrap_t1", 32'(tstate), 32'h01);

      // Single step, with a second step while armed ignored.
      run = 1'b0;
      repeat (16) tick();
      align();
      t_before = m_t;
      n_en = 0; n_en2 = 0;
      step = 1'b1; tick(); step = 1'b0;
      check("step_armed", 32'(sched_st), 32'd2);
      step = 1'b1; tick(); step = 1'b0;
      repeat (20) tick();
      check("step_one_en", 32'(n_en), 32'd1);
      check("step_one_en2", 32'(n_en2), 32'd1);
      check("step_advance", 32'(tstate), 32'(1) << ((t_before + 1) % N));
      check("step_back_stop", 32'(sched_st), 32'd0);

      // Halt decoded in T4.
      run = 1'b1;
      for (int i = 0; i < 200 && m_mode != 3; i++) begin
         halt = (m_t == 3);
         tick();
      end
      halt = 1'b0;
      n_en = 0; n_en2 = 0;
      repeat (8) tick();
      check("halt_en2_follows", 32'(n_en2), 32'd1);
      check("halt_tstate_t5", 32'(tstate), 32'h10);
      check("halt_flag", 32'(halted), 32'd1);
      n_en = 0;
      step = 1'b1; tick(); step = 1'b0;
      repeat (16) tick();
      check("halt_step_ignored", 32'(n_en), 32'd0);
      resume = 1'b1; tick(); resume = 1'b0;
      repeat (16) tick();
      check("resume_restart", 32'(n_en >= 1), 32'd1);

      // Short cycle: tclr during T3.
      for (int i = 0; i < 100 && !(cpu_en && tstate == 6'h04); i++) begin
         tclr = (m_t == 2);
         tick();
      end
      check("tclr_reached_t3", 32'(cpu_en && tstate == 6'h04), 32'd1);
      tclr = (m_t == 2);
      tick();
      tclr = 1'b0;
      check("tclr_back_t1", 32'(tstate), 32'h01);

      // Asynchronous reset between a passed clken and its clken2.
      for (int i = 0; i < 20 && !cpu_en; i++) tick();
      check("rst_saw_en", 32'(cpu_en), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_cpu_en", 32'(cpu_en), 32'd0);
      check("rst_cpu_en2", 32'(cpu_en2), 32'd0);
      check("rst_tstate", 32'(tstate), 32'h01);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_sched_st", 32'(sched_st), 32'd0);
      model_reset();
      n_en2 = 0;
      repeat (8) tick();
      check("rst_no_en2", 32'(n_en2), 32'd0);
      reset = 1'b1;
      run = 1'b0;

`ifdef CLK_SCHED_ISTEP_EN
      // Instruction step: full cycle, then a cycle cut short by tclr in T4.
      align();
      n_en = 0;
      istep = 1'b1; step = 1'b1; tick(); step = 1'b0; istep = 1'b0;
      repeat (60) tick();
      check("istep_six", 32'(n_en), 32'd6);
      check("istep_t1", 32'(tstate), 32'h01);
      check("istep_stop", 32'(sched_st), 32'd0);
      align();
      n_en = 0;
      istep = 1'b1; step = 1'b1; tick(); step = 1'b0; istep = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tclr = (m_t == 3);
         tick();
      end
      tclr = 1'b0;
      check("istep_tclr_four", 32'(n_en), 32'd4);
      check("istep_tclr_stop", 32'(sched_st), 32'd0);
`endif

      // Random mix of controls.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(39) == 0) run = ~run;
         step   = ($urandom_range(19) == 0);
         resume = ($urandom_range(29) == 0);
         halt   = ($urandom_range(24) == 0);
         tclr   = ($urandom_range(9) == 0);
`ifdef CLK_SCHED_ISTEP_EN
         istep  = ($urandom_range(1) == 0);
`endif
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
